// File: rtl/conv_out_receiver_pkg.sv
// Shared NoC definitions: packet field layout, type encoding, node ids, receiver FSM states.
package conv_out_receiver_pkg;

    // Packet field positions and widths
    localparam int PKT_TYPE_BIT = 56;
    localparam int SRC_LSB      = 52;
    localparam int SRC_W        = 4;
    localparam int DEST_LSB     = 48;
    localparam int DEST_W       = 4;
    localparam int ROUTE_LSB    = 40;
    localparam int ROUTE_W      = 8;
    localparam int ADDR_LSB     = 13;
    localparam int ADDR_W       = 27;
    localparam int DATA_LSB     = 0;
    localparam int DATA_W       = 13;

    // Packet type encoding
    localparam logic PKT_TYPE_CONV_OUT = 1'b0;

    // Node addresses
    localparam logic [DEST_W-1:0] NODE_ID_13 = 4'd13;
    localparam logic [DEST_W-1:0] NODE_ID_14 = 4'd14;
    localparam logic [DEST_W-1:0] NODE_ID_15 = 4'd15;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } rx_state_e;

endpackage

// File: rtl/conv_out_buffer.sv
// Output-map buffer: accumulating write port, registered read port, bulk valid clear.
module conv_out_buffer #(
    parameter int DEPTH = 21,
    parameter int DW    = 13,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          wr_hit_o,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DW-1:0]    mem_q [DEPTH];

    // Valid bit of the entry being written; decides store vs accumulate
    always_comb begin
        wr_hit_o = 1'b0;
        if (waddr_i < AW'(DEPTH)) wr_hit_o = vld_q[waddr_i];
    end

    // Valid bits: async reset, bulk clear wins over a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            vld_q <= '0;
        else if (clr_i)                        vld_q <= '0;
        else if (we_i && waddr_i < AW'(DEPTH)) vld_q[waddr_i] <= 1'b1;
    end

    // Data array: first write stores, later writes add modulo 2^DW
    always_ff @(posedge clk) begin
        if (we_i && !clr_i && waddr_i < AW'(DEPTH))
            mem_q[waddr_i] <= wr_hit_o ? mem_q[waddr_i] + wdata_i : wdata_i;
    end

    // Registered read; invalid or out-of-range entries read as zero, pre-write value on collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_o <= '0;
        else if (re_i) begin
            if (raddr_i < AW'(DEPTH) && vld_q[raddr_i]) rdata_o <= mem_q[raddr_i];
            else                                        rdata_o <= '0;
        end
    end

endmodule

// File: rtl/conv_out_receiver.sv
// Conv-output receiver: decodes NoC packets, fills the output map, flags misroutes and bad addresses.
module conv_out_receiver
    import conv_out_receiver_pkg::*;
#(
    parameter int PACKET_WIDTH = 57,
    parameter int PSUM_WIDTH   = 13,
    parameter int DEPTH_P      = 21,
    parameter int NODE_ID      = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pkt_in_valid,
    output logic                    pkt_in_ready,
    input  logic [PACKET_WIDTH-1:0] pkt_in_data,
    input  logic                    frame_clr,
    input  logic                    rd_en,
    input  logic [4:0]              rd_addr,
    output logic [PSUM_WIDTH-1:0]   rd_data,
    output logic [4:0]              out_count,
    output logic                    frame_done,
    output logic                    err_misroute,
    output logic                    err_addr
);

    localparam int AW = 5;

    rx_state_e       state_q, state_d;
    logic [AW-1:0]   count_q, count_d;
    logic            em_q, em_d, ea_q, ea_d;

    logic                  accept, misroute, bad_addr, wr_en, wr_hit;
    logic [ADDR_W-1:0]     pkt_addr;
    logic [DEST_W-1:0]     pkt_dest;
    logic [DATA_W-1:0]     pkt_data;
    logic                  unused_pkt;

    assign pkt_addr   = pkt_in_data[ADDR_LSB +: ADDR_W];
    assign pkt_dest   = pkt_in_data[DEST_LSB +: DEST_W];
    assign pkt_data   = pkt_in_data[DATA_LSB +: DATA_W];
    assign unused_pkt = ^{pkt_in_data[SRC_LSB +: SRC_W], pkt_in_data[ROUTE_LSB +: ROUTE_W]};

    // Handshake and decode; ready never depends on valid
    always_comb begin
        pkt_in_ready = (state_q == ST_COLLECT) && !frame_clr;
        accept       = pkt_in_valid && pkt_in_ready;
        misroute     = (pkt_in_data[PKT_TYPE_BIT] != PKT_TYPE_CONV_OUT) ||
                       (pkt_dest != DEST_W'(NODE_ID));
        bad_addr     = !misroute && (pkt_addr >= ADDR_W'(DEPTH_P));
        wr_en        = accept && !misroute && !bad_addr;
    end

    conv_out_buffer #(
        .DEPTH (DEPTH_P),
        .DW    (PSUM_WIDTH),
        .AW    (AW)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (frame_clr),
        .we_i     (wr_en),
        .waddr_i  (pkt_addr[AW-1:0]),
        .wdata_i  (pkt_data),
        .wr_hit_o (wr_hit),
        .re_i     (rd_en),
        .raddr_i  (rd_addr),
        .rdata_o  (rd_data)
    );

    // Next state: frame_clr first, then error flags, then count and frame completion
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        em_d    = em_q;
        ea_d    = ea_q;
        if (frame_clr) begin
            state_d = ST_COLLECT;
            count_d = '0;
            em_d    = 1'b0;
            ea_d    = 1'b0;
        end else if (accept) begin
            if (misroute)      em_d = 1'b1;
            else if (bad_addr) ea_d = 1'b1;
            else if (!wr_hit) begin
                count_d = count_q + 1'b1;
                if (count_d == AW'(DEPTH_P)) state_d = ST_DONE;
            end
        end
    end

    // State, count and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            count_q <= '0;
            em_q    <= 1'b0;
            ea_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            em_q    <= em_d;
            ea_q    <= ea_d;
        end
    end

    assign out_count    = count_q;
    assign frame_done   = (state_q == ST_DONE);
    assign err_misroute = em_q;
    assign err_addr     = ea_q;

endmodule

// File: doc/conv_out_receiver.md
CONV_OUT_RECEIVER -- requirements
Module: conv_out_receiver

Interface
REQ-001 The block SHALL have these parameters:
- PACKET_WIDTH, 57, NoC packet width.
- PSUM_WIDTH, 13, conv-output data width.
- DEPTH_P, 21, number of output-map entries per frame.
- NODE_ID, 15, NoC address of this node.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- pkt_in_valid  in  1  incoming packet valid.
- pkt_in_ready  out  1  packet accepted when valid&ready at rising clk.
- pkt_in_data  in  57  NoC packet.
- frame_clr  in  1  one-cycle pulse; clears buffer, count, errors; rearms the block.
- rd_en  in  1  read request.
- rd_addr  in  5  read address.
- rd_data  out  13  registered read data.
- out_count  out  5  number of distinct entries written this frame.
- frame_done  out  1  all DEPTH_P entries written.
- err_misroute  out  1  sticky; wrong dest or type seen.
- err_addr  out  1  sticky; psum address >= DEPTH_P seen.

Function
REQ-003 The packet layout SHALL be:
- [56] type (0 = conv-out).
- [55:52] source.
- [51:48] dest.
- [47:40] routing: x_dir, x_hop[2:0], y_dir, y_hop[2:0].
- [39:13] psum_addr.
- [12:0] conv data.
REQ-004 The block SHALL have FSM states COLLECT and DONE; reset enters COLLECT.
REQ-005 pkt_in_ready SHALL be 1 only in COLLECT with frame_clr=0; it is combinational from state and frame_clr only, never from pkt_in_valid.
REQ-006 An accepted packet with dest != NODE_ID or type != 0 SHALL be consumed and dropped, with err_misroute set the next cycle.
REQ-007 Otherwise, an accepted packet with psum_addr >= DEPTH_P SHALL be dropped, with err_addr set the next cycle.
REQ-008 Otherwise, buffer entry psum_addr[4:0] SHALL be updated on the accepting edge:
- If the entry's valid bit is clear: store the data, set the valid bit, increment out_count.
- If the valid bit is set: add the data modulo 2^13 (partial contributions from both psum nodes), out_count unchanged.
REQ-009 When an accept raises out_count to DEPTH_P, the FSM SHALL enter DONE on that edge, so frame_done=1 and pkt_in_ready=0 from the next cycle.
REQ-010 In DONE, frame_done SHALL stay 1 and no packet SHALL be accepted until frame_clr.
REQ-011 frame_clr SHALL, at the next edge and from either state:
- clear all valid bits, out_count and both error flags;
- return the FSM to COLLECT.
It has priority over any simultaneous packet.
REQ-012 rd_en=1 SHALL load rd_data on the next edge:
- rd_addr < DEPTH_P: the entry value if valid, else 0.
- rd_addr >= DEPTH_P: 0.
When rd_en=0, rd_data SHALL hold its value.
REQ-013 A read and a write to the same entry in the same cycle SHALL return the pre-write value.
REQ-014 Reads SHALL be legal in both states and SHALL NOT change buffer state.
REQ-015 Entry data is unspecified while its valid bit is clear and SHALL never be observable on rd_data.

Reset
REQ-016 Asserting rst_n=0 SHALL immediately, without waiting for clk:
- set the FSM to COLLECT;
- clear all valid bits;
- set rd_data, out_count, frame_done, err_misroute and err_addr to 0.
This applies mid-frame and mid-handshake; a packet presented during reset is not accepted.
REQ-017 After rst_n rises, pkt_in_ready SHALL be 1 from the first clk edge onward.

Structure
REQ-018 A shared NoC package SHALL hold:
- packet field bit positions and widths;
- the type encoding;
- NODE_ID constants for nodes 13, 14 and 15;
- the FSM state enum.
REQ-019 The DEPTH_P x 13 data array with its valid bits SHALL be a sub-module, conv_out_buffer: one write port, one registered read port, a bulk clear for valid bits. FSM, decode and counters stay in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Frame fill: 21 packets, dest 15, addr 0..20, data = addr+100 -> frame_done=1 one cycle after the 21st accept; out_count=21; pkt_in_ready=0; reading addr 7 -> 107.
- Accumulation: addr 3 data 0x1FFF from source 13, then data 2 from source 14 -> rd addr 3 = 1; out_count=1.
- Misroute and bad address: dest 14 -> err_misroute=1, out_count=0. Then addr 25 -> err_addr=1, nothing written. frame_clr -> both flags 0.
- Collision: frame_clr in the same cycle as a valid packet -> packet not accepted and still pending; accepted on the next cycle.
- Reset mid-frame: rst_n low after 10 accepts -> all outputs 0 immediately; after release, reading addr 5 -> 0, out_count=0.
- Read edges: rd_addr 21 -> rd_data 0. Simultaneous write and read of addr 4 (old value 9, new data 5) -> rd_data 9 that cycle, 14 on the next read.
